// File: rtl/mx_pkg.sv
// Shared Manchester framing definitions, used by both the transmitter and the receiver.
package mx_pkg;

  typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, CRC, EOF} xmit_state_t;

  localparam logic [7:0] MX_PREAMBLE = 8'hAA;
  localparam logic [7:0] MX_SFD      = 8'hD0;

endpackage

// File: rtl/mx_frame_xmit_if.sv
// Front-end write/command port and line-side status of the Manchester frame transmitter.
interface mx_frame_xmit_if #(
  parameter int DEPTH = 256
);
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic [7:0]       data_in;
  logic             wr_en;
  logic             buf_clear;
  logic             send;
  logic             txd;
  logic             txen;
  logic             busy;
  logic [LEN_W-1:0] buf_len;
  logic             buf_full;
  logic             wr_err;
  logic             xmit_done;

  modport master (
    output data_in, wr_en, buf_clear, send,
    input  txd, txen, busy, buf_len, buf_full, wr_err, xmit_done
  );

  modport slave (
    input  data_in, wr_en, buf_clear, send,
    output txd, txen, busy, buf_len, buf_full, wr_err, xmit_done
  );
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (init 0, MSB feedback); fed one bit per enable in line order.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);
  logic [7:0] crc_d, crc_q;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ bit_in;
    crc_d = crc_q;
    if (clr)
      crc_d = 8'h00;
    else if (en)
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= 8'h00;
    else      crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/mx_frame_xmit.sv
// Manchester frame transmitter: buffers one frame, then sends preamble, SFD, payload,
// optional CRC-8 and an idle-high gap. The frame stays buffered for retransmission.
module mx_frame_xmit
  import mx_pkg::*;
#(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         BIT_RATE       = 50_000,
  parameter int         PREAMBLE_BYTES = 2,
  parameter int         DEPTH          = 256,
  parameter int         CRC_EN         = 1,
  parameter logic [7:0] CRC_POLY       = 8'h07,
  parameter int         EOF_BITS       = 2
) (
  input  logic            clk,
  input  logic            rst,
  mx_frame_xmit_if.slave  bus
);
  localparam int BIT_CLKS = CLK_FREQ / BIT_RATE;
  localparam int PH_W     = $clog2(BIT_CLKS);
  localparam int AW       = $clog2(DEPTH);
  localparam int LEN_W    = AW + 1;
  localparam int CNT_W    = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_CLKS - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(BIT_CLKS / 2);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BYTES - 1);
  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);

  xmit_state_t      state_d, state_q;
  logic [PH_W-1:0]  phase_d, phase_q;
  logic [2:0]       bit_d, bit_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [7:0]       sh_d, sh_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic             txd_d, txd_q, txen_d, txen_q;
  logic             done_d, done_q, wr_err_d, wr_err_q;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    rd_idx, addr;
  logic [7:0]       ram_rd, crc_val;
  logic             idle, full, wrap, we, crc_clr, crc_en;

  assign idle   = (state_q == IDLE);
  assign full   = (len_q == LEN_W'(DEPTH));
  assign wrap   = (phase_q == PH_LAST);
  assign rd_idx = (state_q == PAY) ? AW'(cnt_q + CNT_W'(1)) : '0;
  // Writes only happen in IDLE and reads only while sending, so one address port suffices.
  assign addr   = idle ? len_q[AW-1:0] : rd_idx;
  assign ram_rd = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= bus.data_in;
  end

  crc8_serial #(.POLY(CRC_POLY)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (sh_d[0]),
    .crc    (crc_val)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    len_d    = len_q;
    we       = 1'b0;
    wr_err_d = 1'b0;
    crc_clr  = 1'b0;
    phase_d  = wrap ? '0 : phase_q + PH_W'(1);

    // A clear in IDLE swallows a simultaneous write silently.
    if (bus.wr_en && !(idle && bus.buf_clear)) begin
      if (idle && !full) we = 1'b1;
      else               wr_err_d = 1'b1;
    end
    if (idle && bus.buf_clear) len_d = '0;
    else if (we)               len_d = len_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (bus.send && !bus.buf_clear && (len_q != '0 || we)) begin
          state_d = PRE;
          bit_d   = '0;
          cnt_d   = '0;
          sh_d    = MX_PREAMBLE;
          crc_clr = 1'b1;
        end
      end
      EOF: begin
        if (wrap) begin
          if (cnt_q == EOF_LAST) state_d = IDLE;
          else                   cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (wrap && bit_q != 3'd7) begin
          bit_d = bit_q + 3'd1;
          sh_d  = {1'b0, sh_q[7:1]};
        end else if (wrap) begin
          bit_d = '0;
          cnt_d = '0;
          case (state_q)
            PRE: begin
              if (cnt_q == PRE_LAST) begin
                state_d = SFD;
                sh_d    = MX_SFD;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sh_d  = MX_PREAMBLE;
              end
            end
            SFD: begin
              state_d = PAY;
              sh_d    = ram_rd;
            end
            PAY: begin
              if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
                state_d = (CRC_EN != 0) ? CRC : EOF;
                sh_d    = crc_val;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sh_d  = ram_rd;
              end
            end
            default: state_d = EOF;
          endcase
        end
      end
    endcase

    // Outputs are registered from next-state values so they line up with the state.
    crc_en = !idle && wrap && (state_d == PAY);
    txen_d = (state_d != IDLE);
    txd_d  = 1'b1;
    if (state_d inside {PRE, SFD, PAY, CRC})
      txd_d = (phase_d < PH_HALF) ? sh_d[0] : ~sh_d[0];
    done_d = (state_d == EOF) && (phase_d == PH_LAST) && (cnt_d == EOF_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      len_q    <= '0;
      txd_q    <= 1'b1;
      txen_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      len_q    <= len_d;
      txd_q    <= txd_d;
      txen_q   <= txen_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.txd       = txd_q;
  assign bus.txen      = txen_q;
  assign bus.busy      = !idle;
  assign bus.buf_len   = len_q;
  assign bus.buf_full  = full;
  assign bus.wr_err    = wr_err_q;
  assign bus.xmit_done = done_q;
endmodule

// File: tb/tb_mx_frame_xmit.sv
// Bench for mx_frame_xmit: one instance with CRC, one without, sharing the front-end inputs.
`timescale 1ns/1ps
module tb_mx_frame_xmit;
  localparam int CLK_FREQ = 8;
  localparam int BIT_RATE = 1;
  localparam int BC       = CLK_FREQ / BIT_RATE;
  localparam int DEPTH    = 16;
  localparam int PRE_A    = 2;
  localparam int EOF_A    = 3;
  localparam int PRE_B    = 1;
  localparam int EOF_B    = 2;
  localparam int INJ_K    = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       wr_en = 1'b0, buf_clear = 1'b0, send = 1'b0;
  int         n_vec = 0, n_err = 0;
  logic [7:0] mdl[$];

  always #5 clk = ~clk;

  mx_frame_xmit_if #(.DEPTH(DEPTH)) bus_a ();
  mx_frame_xmit_if #(.DEPTH(DEPTH)) bus_b ();

  assign bus_a.data_in = data_in;   assign bus_b.data_in = data_in;
  assign bus_a.wr_en = wr_en;       assign bus_b.wr_en = wr_en;
  assign bus_a.buf_clear = buf_clear; assign bus_b.buf_clear = buf_clear;
  assign bus_a.send = send;         assign bus_b.send = send;

  mx_frame_xmit #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PREAMBLE_BYTES(PRE_A),
                  .DEPTH(DEPTH), .CRC_EN(1), .CRC_POLY(8'h07), .EOF_BITS(EOF_A))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  mx_frame_xmit #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PREAMBLE_BYTES(PRE_B),
                  .DEPTH(DEPTH), .CRC_EN(0), .CRC_POLY(8'h07), .EOF_BITS(EOF_B))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic       wr;
    logic       clr;
    logic       snd;
    logic [7:0] d;
    int         exp_len;
    logic       exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] pl[$]);
    logic [7:0] c;
    logic [7:0] cur;
    logic       fb;
    c = 8'h00;
    foreach (pl[i]) begin
      cur = pl[i];
      for (int b = 0; b < 8; b++) begin
        fb = c[7] ^ cur[b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // Expected line level for every cycle of a frame, starting with the first half-bit.
  task automatic build_wave(input logic [7:0] pl[$], input int pre, input bit crc_en,
                            input int eofb, output logic wv[$], output logic [7:0] by[$]);
    logic [7:0] cur;
    by = {};
    wv = {};
    for (int i = 0; i < pre; i++) by.push_back(8'hAA);
    by.push_back(8'hD0);
    foreach (pl[i]) by.push_back(pl[i]);
    if (crc_en) by.push_back(ref_crc(pl));
    foreach (by[i]) begin
      cur = by[i];
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < BC; c++) wv.push_back((c < BC / 2) ? cur[b] : ~cur[b]);
    end
    for (int c = 0; c < eofb * BC; c++) wv.push_back(1'b1);
  endtask

  function automatic logic [7:0] dec_byte(input logic cap[$], input int j);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = cap[(j * 8 + b) * BC + 1];
    return v;
  endfunction

  task automatic wr_byte(input logic [7:0] d, output logic err);
    @(negedge clk);
    data_in = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    err   = bus_a.wr_err;
    if (mdl.size() < DEPTH) mdl.push_back(d);
  endtask

  task automatic clr_buf();
    @(negedge clk);
    buf_clear = 1'b1;
    @(negedge clk);
    buf_clear = 1'b0;
    mdl.delete();
  endtask

  task automatic send_and_check(input string tag, input bit has_wr, input logic [7:0] wbyte,
                                input bit inject);
    logic       wa[$], wb[$], ca[$], cb[$];
    logic [7:0] ba[$], bb[$];
    int la, lb, n, bad_a, bad_b, en_a, en_b, dn_a, dn_b, dec_a, dec_b;
    if (has_wr && mdl.size() < DEPTH) mdl.push_back(wbyte);
    build_wave(mdl, PRE_A, 1'b1, EOF_A, wa, ba);
    build_wave(mdl, PRE_B, 1'b0, EOF_B, wb, bb);
    la = wa.size();
    lb = wb.size();
    n  = ((la > lb) ? la : lb) + 4;
    bad_a = 0; bad_b = 0; en_a = 0; en_b = 0; dn_a = 0; dn_b = 0; dec_a = 0; dec_b = 0;
    @(negedge clk);
    send    = 1'b1;
    wr_en   = has_wr;
    data_in = wbyte;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        send  = 1'b0;
        wr_en = 1'b0;
      end
      if (inject && k == INJ_K + 1) begin
        send  = 1'b0;
        wr_en = 1'b0;
        check({tag, "_busy_wr_err"}, bus_a.wr_err, 1'b1);
        check({tag, "_busy_len"}, bus_a.buf_len, mdl.size());
      end
      if (inject && k == INJ_K) begin
        send    = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'hEE;
      end
      if (bus_a.txen !== (k < la) || bus_a.txd !== ((k < la) ? wa[k] : 1'b1)) bad_a++;
      if (bus_b.txen !== (k < lb) || bus_b.txd !== ((k < lb) ? wb[k] : 1'b1)) bad_b++;
      if (bus_a.txen) en_a++;
      if (bus_b.txen) en_b++;
      if (bus_a.xmit_done) begin dn_a++; if (k != la - 1) bad_a++; end
      if (bus_b.xmit_done) begin dn_b++; if (k != lb - 1) bad_b++; end
      ca.push_back(bus_a.txd);
      cb.push_back(bus_b.txd);
    end
    foreach (ba[j]) if (dec_byte(ca, j) !== ba[j]) dec_a++;
    foreach (bb[j]) if (dec_byte(cb, j) !== bb[j]) dec_b++;
    check({tag, "_wave_a_bad_cycles"}, bad_a, 0);
    check({tag, "_wave_b_bad_cycles"}, bad_b, 0);
    check({tag, "_txen_cycles_a"}, en_a, la);
    check({tag, "_txen_cycles_b"}, en_b, lb);
    check({tag, "_done_pulses_a"}, dn_a, 1);
    check({tag, "_done_pulses_b"}, dn_b, 1);
    check({tag, "_decode_a_bad_bytes"}, dec_a, 0);
    check({tag, "_decode_b_bad_bytes"}, dec_b, 0);
    check({tag, "_crc_byte"}, dec_byte(ca, ba.size() - 1), ref_crc(mdl));
    check({tag, "_len_after"}, bus_a.buf_len, mdl.size());
  endtask

  initial begin
    vec_t       tbl[8];
    logic       err;
    logic [7:0] frame1[5];
    int         nerr;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h5A, 1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h44, 2, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h77, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h01, 1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    frame1 = '{8'h5A, 8'h44, 8'h30, 8'h68, 8'h69};

    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", bus_a.txd, 1'b1);
    check("reset_txen", bus_a.txen, 1'b0);
    check("reset_busy", bus_a.busy, 1'b0);
    check("reset_len", bus_a.buf_len, 0);
    check("reset_done_err", {bus_a.xmit_done, bus_a.wr_err}, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en     = tbl[i].wr;
      buf_clear = tbl[i].clr;
      send      = tbl[i].snd;
      data_in   = tbl[i].d;
      @(posedge clk);
      #1;
      wr_en = 1'b0; buf_clear = 1'b0; send = 1'b0;
      check($sformatf("tbl%0d_len", i), bus_a.buf_len, tbl[i].exp_len);
      check($sformatf("tbl%0d_wr_err", i), bus_a.wr_err, tbl[i].exp_err);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("tbl%0d_busy", i), bus_a.busy, 1'b0);
      check($sformatf("tbl%0d_txen_b", i), bus_b.txen, 1'b0);
    end
    mdl.delete();

    foreach (frame1[i]) wr_byte(frame1[i], err);
    send_and_check("frame1", 1'b0, 8'h00, 1'b0);
    send_and_check("retx", 1'b0, 8'h00, 1'b1);

    for (int r = 0; r < 4; r++) begin
      clr_buf();
      for (int i = 0; i < $urandom_range(6, 1); i++) wr_byte(8'($urandom), err);
      send_and_check($sformatf("rand%0d", r), r[0], 8'($urandom), 1'b0);
    end

    clr_buf();
    nerr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_byte(8'($urandom), err);
      if (err) nerr++;
    end
    check("fill_no_err", nerr, 0);
    check("fill_full", bus_a.buf_full, 1'b1);
    wr_byte(8'hC3, err);
    check("overflow_wr_err", err, 1'b1);
    check("overflow_len", bus_a.buf_len, DEPTH);
    send_and_check("full_frame", 1'b0, 8'h00, 1'b0);

    clr_buf();
    foreach (frame1[i]) if (i < 4) wr_byte(frame1[i], err);
    @(negedge clk);
    send = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
    repeat ((PRE_A + 1 + 2) * 8 * BC + 20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_txd", {bus_a.txd, bus_b.txd}, 2'b11);
    check("midrst_txen", {bus_a.txen, bus_b.txen}, 2'b00);
    check("midrst_busy", {bus_a.busy, bus_b.busy}, 2'b00);
    check("midrst_len", bus_a.buf_len, 0);
    @(negedge clk);
    rst = 1'b1;
    mdl.delete();
    wr_byte(8'hC5, err);
    wr_byte(8'h3E, err);
    send_and_check("post_rst", 1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mx_frame_xmit.md
Name: mx_frame_xmit

Overview:
- Parametrised Manchester frame transmitter; successor to the fixed-rate transmit path inside wimpfi_top.
- Buffers one complete frame (dest, src, type, data) written byte-wise by the MAC/UART front end.
- On command, serialises preamble, SFD, payload and optional CRC-8, then an end-of-frame idle gap.
- Retains the frame after transmission, so the MAC can retransmit on ACK timeout or backoff without re-feeding bytes.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BIT_RATE, 50_000, Manchester bit rate in bit/s; BIT_CLKS = CLK_FREQ/BIT_RATE must be even and >= 4.
- PREAMBLE_BYTES, 2, number of 8'hAA preamble bytes (1..15).
- DEPTH, 256, frame buffer depth in bytes; power of 2.
- CRC_EN, 1, 1 appends a CRC-8 byte after the payload.
- CRC_POLY, 8'h07, CRC-8 polynomial, with init 8'h00.
- EOF_BITS, 2, idle-high bit periods after the last bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  8  payload byte.
- wr_en  in  1  write data_in into the buffer this cycle.
- buf_clear  in  1  empty the buffer (length := 0).
- send  in  1  single-cycle request to transmit the buffered frame.
- txd  out  1  Manchester line output; idle 1.
- txen  out  1  high from the first preamble half-bit through the end of the EOF gap.
- busy  out  1  state != IDLE.
- buf_len  out  $clog2(DEPTH)+1  number of bytes buffered.
- buf_full  out  1  buf_len == DEPTH.
- wr_err  out  1  one-cycle pulse when a write is dropped.
- xmit_done  out  1  one-cycle pulse at the end of the EOF gap.

Behaviour:
- Reset (rst=0, asynchronous): txd=1, txen=0, busy=0, buf_len=0, wr_err=0, xmit_done=0, state=IDLE. Reset mid-frame aborts the frame immediately; buffer contents are discarded.
- Encoding:
  - Each bit occupies BIT_CLKS cycles: first half = bit, second half = ~bit (1 = high then low).
  - Bits are sent LSB first.
- Writes:
  - Accepted only in IDLE with buf_full=0; the byte is stored at index buf_len, and buf_len increments the next cycle.
  - A write while busy or full is dropped and pulses wr_err.
  - buf_clear in IDLE zeroes buf_len; buf_clear while busy is ignored.
  - If buf_clear and wr_en occur in the same cycle, clear wins and the byte is dropped without wr_err.
- send:
  - Accepted only in IDLE with buf_len > 0.
  - Otherwise ignored, with no error and no done pulse.
  - A send coinciding with wr_en: the write is accepted first; the frame includes that byte.
- Latency: txen and the first half-bit appear in the cycle after send is sampled.
- State machine:
  - IDLE -> PRE on accepted send.
  - PRE: PREAMBLE_BYTES x 8'hAA, then -> SFD.
  - SFD: 8'hD0, then -> PAY.
  - PAY: bytes 0..buf_len-1, then -> CRC if CRC_EN, else -> EOF.
  - CRC: one CRC byte, then -> EOF.
  - EOF: txd=1, txen=1 for EOF_BITS*BIT_CLKS cycles, then -> IDLE with xmit_done pulsed in the last EOF cycle.
  - txen drops in the cycle after that; busy follows state.
- CRC:
  - Covers payload bytes only, processed bit-serially in transmission order.
  - Per bit: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - The CRC byte is transmitted LSB first, like data.
  - The CRC is reset to 8'h00 at every accepted send.
- Retransmit: the buffer is preserved after xmit_done; a subsequent send re-sends an identical frame, including the same CRC.
- Counters:
  - The bit-phase counter runs 0..BIT_CLKS-1 and wraps.
  - The byte index wraps only via a state change; with buf_len == DEPTH all DEPTH bytes are sent.
- send during busy is ignored: no queuing, no restart.

Decomposition:
- Package mx_pkg:
  - xmit_state_t enum {IDLE, PRE, SFD, PAY, CRC, EOF};
  - constants MX_PREAMBLE = 8'hAA and MX_SFD = 8'hD0.
  - Shared with the receiver.
- Sub-module crc8_serial (clk, rst, clr, en, bit_in, crc[7:0]) with parameter POLY; the receiver reuses it for CRC checking.
- Frame buffer is an inferred single-port RAM in the top module.

Test Plan:
- Write 5A 44 30 68 69 with CRC_EN=0, PREAMBLE_BYTES=1, then pulse send.
  - Decoded stream is AA D0 5A 44 30 68 69.
  - txen high for exactly (56+2)*2000 cycles; single xmit_done pulse; txd=1 after.
- Same frame with CRC_EN=1.
  - The 8th decoded byte equals the bench reference CRC-8 (poly 07, init 00, LSB-first) over 5A 44 30 68 69.
  - Bitstream half-periods are exactly 1000 cycles.
- Retransmit: after xmit_done, pulse send again without writing.
  - Identical bitstream and CRC; buf_len stays 5.
- Errors:
  - wr_en mid-frame -> wr_err pulse, buf_len unchanged.
  - send with buf_len=0 -> no txen.
  - Fill DEPTH bytes then write -> wr_err; buf_full=1.
- Drive rst low during the PAY state of the 3rd byte.
  - Same cycle: txd=1, txen=0, busy=0, buf_len=0.
  - After release, a new 2-byte frame transmits cleanly.
- buf_clear and wr_en in the same cycle in IDLE -> buf_len=0, no wr_err.
  - A following send is ignored.
